// File: rtl/imem_fetch_ctrl.sv
// Owns both inst_mem ports: streams loader words to the write port; fetches {pc, instr} into a 3-deep buffer.
// First if_valid two cycles after fetch starts, then 1/cycle; stalls on !if_ready, ld_ready drops while fetching.
module imem_fetch_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    input  logic              run,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr_w,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_addr_r,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;

    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic              ld_done_q, ld_done_d;
    logic              ld_err_q, ld_err_d;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_pc_q;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] buf_pc_q [3];
    logic [ADDR_W-1:0] buf_pc_d [3];
    logic [DATA_W-1:0] buf_instr_q [3];
    logic [DATA_W-1:0] buf_instr_d [3];

    logic       accept, in_fetch, pop, flush, issue, push;
    logic [2:0] occ;
    logic [1:0] wr_idx;

    always_comb begin
        ld_ready = !clr && (state_q != S_FETCH);
        accept   = ld_valid && ld_ready;
        in_fetch = !clr && (state_q == S_FETCH);
        if_valid = !clr && (cnt_q != 2'd0);
        pop      = if_valid && if_ready;
        flush    = in_fetch && (br_valid || !run);
        // The read in flight already owns a buffer slot, so count it before issuing another.
        occ      = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
        issue    = in_fetch && !flush && (occ < 3'd3);
        push     = rd_vld_q && !flush;
    end

    assign mem_we      = accept;
    assign mem_addr_w  = ld_ptr_q;
    assign mem_data_in = ld_data;
    assign mem_addr_r  = clr ? RST_PC : pc_q;
    assign busy        = !clr && (state_q != S_IDLE);
    assign ld_done     = ld_done_q;
    assign ld_err      = ld_err_q;
    assign if_pc       = buf_pc_q[0];
    assign if_instr    = buf_instr_q[0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ld_ptr_d  = ld_ptr_q;
        ld_err_d  = ld_err_q;
        ld_done_d = accept && ld_last;
        if (accept) begin
            if (state_q == S_IDLE) begin
                ld_err_d = 1'b0;
            end
            if (ld_last) begin
                ld_ptr_d = '0;
                state_d  = S_IDLE;
            end else begin
                ld_ptr_d = ld_ptr_q + ADDR_W'(1);
                state_d  = S_LOAD;
                if (ld_ptr_q == PTR_MAX) begin
                    ld_err_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_FETCH;
                        pc_d    = RST_PC;
                    end
                end
                S_LOAD: ;
                S_FETCH: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end
                    if (br_valid) begin
                        pc_d = br_target;
                    end else if (issue) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (pop) begin
            buf_pc_d[0]    = buf_pc_q[1];
            buf_pc_d[1]    = buf_pc_q[2];
            buf_instr_d[0] = buf_instr_q[1];
            buf_instr_d[1] = buf_instr_q[2];
        end
        wr_idx = pop ? (cnt_q - 2'd1) : cnt_q;
        if (push) begin
            buf_pc_d[wr_idx]    = rd_pc_q;
            buf_instr_d[wr_idx] = mem_data_out;
        end
        cnt_d = flush ? 2'd0 : (cnt_q - 2'(pop) + 2'(push));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            pc_q      <= RST_PC;
            ld_ptr_q  <= '0;
            ld_done_q <= 1'b0;
            ld_err_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ld_ptr_q  <= ld_ptr_d;
            ld_done_q <= ld_done_d;
            ld_err_q  <= ld_err_d;
            rd_vld_q  <= issue;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_pc_q     <= pc_q;
        buf_pc_q    <= buf_pc_d;
        buf_instr_q <= buf_instr_d;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed and randomized stimulus for imem_fetch_ctrl; every cycle is compared against a queue-based model.
module tb_imem_fetch_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_FETCH = 2;

    logic          clk = 1'b0;
    logic          clr, ld_valid, ld_last, run, br_valid, if_ready;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] br_target;
    logic          ld_ready, ld_done, ld_err, if_valid, mem_we, busy;
    logic [DW-1:0] if_instr, mem_data_in, mem_data_out;
    logic [AW-1:0] if_pc, mem_addr_w, mem_addr_r;
    logic [DW-1:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
        .clk(clk), .clr(clr),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err),
        .run(run), .br_valid(br_valid), .br_target(br_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .mem_we(mem_we), .mem_addr_w(mem_addr_w), .mem_data_in(mem_data_in),
        .mem_addr_r(mem_addr_r), .mem_data_out(mem_data_out), .busy(busy)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr_w] <= mem_data_in;
        mem_data_out <= mem[mem_addr_r];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: every issued read is a queue entry that becomes visible two cycles after issue.
    typedef struct { int pc; int vis; } rd_t;
    rd_t           q[$];
    logic [DW-1:0] img [DEPTH];
    int            m_mode, m_pc, m_ptr;
    bit            m_done, m_err;

    always @(negedge clk) begin : model_chk
        bit exp_vld, exp_we, pop;
        if (clr) begin
            chk("clr_ld_ready", 32'(ld_ready), 32'(0));
            chk("clr_mem_we", 32'(mem_we), 32'(0));
            chk("clr_if_valid", 32'(if_valid), 32'(0));
            chk("clr_busy", 32'(busy), 32'(0));
            chk("clr_mem_addr_r", 32'(mem_addr_r), 32'(0));
            m_mode = M_IDLE; m_pc = 0; m_ptr = 0; m_done = 0; m_err = 0;
            q.delete();
        end else begin
            exp_we  = ld_valid && (m_mode != M_FETCH);
            exp_vld = (q.size() > 0) && (q[0].vis <= cyc);
            chk("ld_ready", 32'(ld_ready), 32'(m_mode != M_FETCH));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                chk("mem_addr_w", 32'(mem_addr_w), 32'(m_ptr));
                chk("mem_data_in", mem_data_in, ld_data);
            end
            chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
            chk("ld_done", 32'(ld_done), 32'(m_done));
            chk("ld_err", 32'(ld_err), 32'(m_err));
            chk("if_valid", 32'(if_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk("if_pc", 32'(if_pc), 32'(q[0].pc));
                chk("if_instr", if_instr, img[q[0].pc]);
            end
            pop    = exp_vld && if_ready;
            m_done = 0;
            if (exp_we) begin
                img[m_ptr] = ld_data;
                if (m_mode == M_IDLE) m_err = 0;
                if (ld_last) begin
                    m_ptr = 0; m_done = 1; m_mode = M_IDLE;
                end else begin
                    if (m_ptr == DEPTH - 1) m_err = 1;
                    m_ptr  = (m_ptr + 1) % DEPTH;
                    m_mode = M_LOAD;
                end
            end else if (m_mode == M_IDLE) begin
                if (run) begin
                    m_mode = M_FETCH; m_pc = 0;
                end
            end else if (m_mode == M_FETCH) begin
                if (pop) void'(q.pop_front());
                if (br_valid || !run) begin
                    q.delete();
                    if (br_valid) m_pc = int'(br_target);
                    if (!run) m_mode = M_IDLE;
                end else if (q.size() < 3) begin
                    chk("mem_addr_r", 32'(mem_addr_r), 32'(m_pc));
                    q.push_back('{m_pc, cyc + 2});
                    m_pc = (m_pc + 1) % DEPTH;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 0; ld_last = 0; ld_data = '0; run = 0;
        br_valid = 0; br_target = '0; if_ready = 0;
    endtask

    function automatic logic [31:0] wdat(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    int rdy_pat[6] = '{1, 0, 0, 1, 0, 1};
    int pc_pat[6]  = '{4, 5, 5, 5, 6, 6};

    initial begin
        clr = 1;
        idle_inputs();
        tick(); tick();
        clr = 0;

        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = 32'hA0A0_0000 + 32'(i); ld_last = (i == 3);
            @(negedge clk);
            chk("t1_we", 32'(mem_we), 32'(1));
            chk("t1_addr", 32'(mem_addr_w), 32'(i));
            tick();
        end
        ld_valid = 0; ld_last = 0;
        @(negedge clk);
        chk("t1_done", 32'(ld_done), 32'(1));
        chk("t1_idle", 32'(busy), 32'(0));
        chk("t1_mem3", mem[3], 32'hA0A0_0003);
        tick();
        @(negedge clk);
        chk("t1_done_once", 32'(ld_done), 32'(0));
        tick();

        for (int i = 0; i < 1025; i++) begin
            ld_valid = 1; ld_data = wdat(i); ld_last = (i == 1024);
            tick();
        end
        ld_valid = 0; ld_last = 0;
        @(negedge clk);
        chk("t5_ld_err", 32'(ld_err), 32'(1));
        chk("t5_wrap_word", mem[0], wdat(1024));
        chk("t5_mem1", mem[1], wdat(1));
        tick();

        run = 1; if_ready = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t2_valid", 32'(if_valid), 32'(k >= 3));
            if (k >= 3) chk("t2_pc", 32'(if_pc), 32'(k - 3));
            tick();
        end

        for (int k = 0; k < 6; k++) begin
            if_ready = rdy_pat[k][0];
            @(negedge clk);
            chk("t3_valid", 32'(if_valid), 32'(1));
            chk("t3_pc", 32'(if_pc), 32'(pc_pat[k]));
            chk("t3_instr", if_instr, wdat(pc_pat[k]));
            tick();
        end

        if_ready = 0;
        tick();
        br_valid = 1; br_target = 10'h200;
        tick();
        br_valid = 0; if_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_valid", 32'(if_valid), 32'(k >= 2));
            if (k >= 2) chk("t4_pc", 32'(if_pc), 32'h200 + 32'(k - 2));
            tick();
        end

        br_valid = 1; br_target = 10'h3FE;
        tick();
        br_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_valid", 32'(if_valid), 32'(k >= 2));
            if (k == 2) chk("t5_pc", 32'(if_pc), 32'h3FE);
            if (k == 3) chk("t5_pc", 32'(if_pc), 32'h3FF);
            if (k == 4) chk("t5_pc", 32'(if_pc), 32'h000);
            if (k == 4) chk("t5_instr", if_instr, wdat(1024));
            tick();
        end

        clr = 1;
        @(negedge clk);
        chk("t6_clr_valid", 32'(if_valid), 32'(0));
        tick();
        clr = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_busy", 32'(busy), 32'(k >= 1));
            chk("t6_valid", 32'(if_valid), 32'(k >= 3));
            if (k >= 3) chk("t6_pc", 32'(if_pc), 32'(k - 3));
            tick();
        end

        run = 0; if_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1; ld_data = 32'hC0DE_0000 + 32'(i); ld_last = 0;
            tick();
        end
        clr = 1; ld_data = 32'hC0DE_0005;
        @(negedge clk);
        chk("t6_clr_we", 32'(mem_we), 32'(0));
        tick();
        clr = 0; ld_data = 32'hC0DE_0100; ld_last = 1;
        @(negedge clk);
        chk("t6_ptr0", 32'(mem_addr_w), 32'(0));
        chk("t6_we", 32'(mem_we), 32'(1));
        chk("t6_idle", 32'(busy), 32'(0));
        tick();
        ld_valid = 0; ld_last = 0;
        tick();

        for (int n = 0; n < 4000; n++) begin
            clr       = ($urandom_range(0, 399) == 0);
            run       = ($urandom_range(0, 24) != 0);
            br_valid  = ($urandom_range(0, 11) == 0);
            br_target = AW'($urandom_range(0, DEPTH - 1));
            if_ready  = ($urandom_range(0, 3) != 0);
            ld_valid  = ($urandom_range(0, 39) == 0);
            ld_last   = ($urandom_range(0, 1) == 0);
            ld_data   = $urandom;
            tick();
        end

        clr = 0;
        idle_inputs();
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
